// File: rtl/cursor_sprite_core.sv
// rtl/cursor_sprite_core.sv - 32x32 1-bit cursor overlay with frame-synchronous register shadowing and blink
// Three-stage pixel pipeline; host writes land in pending registers and go active on frame_start.
module cursor_sprite_core #(
  parameter int CD           = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          frame_start,
  input  logic [CD-1:0] si_rgb,
  input  logic          wr_en,
  input  logic [1:0]    wr_addr,
  input  logic [15:0]   wr_data,
  output logic [9:0]    ram_addr,
  input  logic          ram_bit,
  output logic [CD-1:0] so_rgb
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [10:0]   pend_x0_q, pend_x0_d, act_x0_q, act_x0_d;
  logic [10:0]   pend_y0_q, pend_y0_d, act_y0_q, act_y0_d;
  logic [CD-1:0] pend_col_q, pend_col_d, act_col_q, act_col_d;
  logic [1:0]    pend_ctrl_q, pend_ctrl_d, act_ctrl_q, act_ctrl_d;
  logic [9:0]    ram_addr_q, ram_addr_d;
  logic          hit_d1_q, hit_d1_d, hit_d2_q, hit_d2_d;
  logic [CD-1:0] rgb_d1_q, rgb_d1_d, rgb_d2_q, rgb_d2_d, so_rgb_q, so_rgb_d;
  logic [7:0]    blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  logic [11:0]   dx, dy;
  logic          hit;
  logic          unused_wr;

  assign unused_wr = ^wr_data;

  // Borrow in bit 11 marks scan positions left/above the cursor, so no wrap-around.
  assign dx  = {1'b0, x} - {1'b0, act_x0_q};
  assign dy  = {1'b0, y} - {1'b0, act_y0_q};
  assign hit = act_ctrl_q[0] & ~dx[11] & (dx[10:5] == 6'd0) & ~dy[11] & (dy[10:5] == 6'd0);

  always_comb begin
    pend_x0_d   = pend_x0_q;
    pend_y0_d   = pend_y0_q;
    pend_col_d  = pend_col_q;
    pend_ctrl_d = pend_ctrl_q;
    if (wr_en) begin
      case (wr_addr)
        2'd0:    pend_x0_d   = wr_data[10:0];
        2'd1:    pend_y0_d   = wr_data[10:0];
        2'd2:    pend_col_d  = wr_data[CD-1:0];
        default: pend_ctrl_d = wr_data[1:0];
      endcase
    end
  end

  // Active copies take the pre-write pending value when a write coincides with frame_start.
  always_comb begin
    act_x0_d   = act_x0_q;
    act_y0_d   = act_y0_q;
    act_col_d  = act_col_q;
    act_ctrl_d = act_ctrl_q;
    if (frame_start) begin
      act_x0_d   = pend_x0_q;
      act_y0_d   = pend_y0_q;
      act_col_d  = pend_col_q;
      act_ctrl_d = pend_ctrl_q;
    end
  end

  // Blink state follows the blink_en that becomes active on the same frame_start.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (frame_start) begin
      if (pend_ctrl_q[1]) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = 8'd0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 8'd1;
        end
      end else begin
        blink_cnt_d = 8'd0;
        phase_d     = 1'b0;
      end
    end else if (!act_ctrl_q[1]) begin
      blink_cnt_d = 8'd0;
      phase_d     = 1'b0;
    end
  end

  always_comb begin
    ram_addr_d = {dy[4:0], dx[4:0]};
    hit_d1_d   = hit;
    rgb_d1_d   = si_rgb;
    hit_d2_d   = hit_d1_q;
    rgb_d2_d   = rgb_d1_q;
    so_rgb_d   = (hit_d2_q & ram_bit & ~phase_q) ? act_col_q : rgb_d2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_x0_q   <= '0;
      pend_y0_q   <= '0;
      pend_col_q  <= '0;
      pend_ctrl_q <= '0;
      act_x0_q    <= '0;
      act_y0_q    <= '0;
      act_col_q   <= '0;
      act_ctrl_q  <= '0;
      ram_addr_q  <= '0;
      hit_d1_q    <= 1'b0;
      hit_d2_q    <= 1'b0;
      rgb_d1_q    <= '0;
      rgb_d2_q    <= '0;
      so_rgb_q    <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      pend_x0_q   <= pend_x0_d;
      pend_y0_q   <= pend_y0_d;
      pend_col_q  <= pend_col_d;
      pend_ctrl_q <= pend_ctrl_d;
      act_x0_q    <= act_x0_d;
      act_y0_q    <= act_y0_d;
      act_col_q   <= act_col_d;
      act_ctrl_q  <= act_ctrl_d;
      ram_addr_q  <= ram_addr_d;
      hit_d1_q    <= hit_d1_d;
      hit_d2_q    <= hit_d2_d;
      rgb_d1_q    <= rgb_d1_d;
      rgb_d2_q    <= rgb_d2_d;
      so_rgb_q    <= so_rgb_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign so_rgb   = so_rgb_q;

endmodule
